// File: rtl/spi_mnrch.sv
// rtl/spi_mnrch.sv - 16-bit SPI mode-3 master carrying sensor register transactions
module spi_mnrch #(
  parameter int DIV_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snd,
  input  logic [DATA_W-1:0] cmd,
  output logic              done,
  output logic [DATA_W-1:0] resp,
  output logic              SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  // Load value puts the first SCLK fall 9 clk after the load (front porch).
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'((1 << DIV_W) - 9);
  // Cycle before SCLK rises: capture MISO here.
  localparam logic [DIV_W-1:0] DIV_SMPL = {1'b0, {(DIV_W-1){1'b1}}};
  // Cycle before SCLK falls (and the final cycle): shift here.
  localparam logic [DIV_W-1:0] DIV_LAST = {DIV_W{1'b1}};

  typedef enum logic [1:0] {IDLE, PORCH, SHIFT} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   shifted;
  logic [CNT_W-1:0]    smpl_cnt;
  logic                miso_smpl;
  logic                div_last;
  logic                last_bit;

  assign div_last = (div == DIV_LAST);
  // The back porch is the tail of SHIFT: the 16th shift lands on the cycle SCLK would fall.
  assign last_bit = (state == SHIFT) && div_last && (smpl_cnt == CNT_W'(DATA_W));
  assign shifted  = {shift_reg[DATA_W-2:0], miso_smpl};

  assign SCLK = (state == IDLE) ? 1'b1 : div[DIV_W-1];
  assign MOSI = shift_reg[DATA_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: porch ends when the divider wraps, shifting ends after the 16th sample
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snd)      state_nxt = PORCH;
      PORCH:   if (div_last) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Datapath: divider, MISO capture, shift register and result handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= '0;
      shift_reg <= '0;
      smpl_cnt  <= '0;
      miso_smpl <= 1'b0;
      resp      <= '0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else if (state == IDLE) begin
      if (snd) begin
        shift_reg <= cmd;
        div       <= DIV_LOAD;
        smpl_cnt  <= '0;
        SS_n      <= 1'b0;
        done      <= 1'b0;
      end
    end else begin
      // Divider freezes on the final cycle so SCLK is left high.
      if (!last_bit) div <= div + DIV_W'(1);
      // MISO is stable for many clk before this point, so no synchroniser.
      if (div == DIV_SMPL) begin
        miso_smpl <= MISO;
        smpl_cnt  <= smpl_cnt + CNT_W'(1);
      end
      if (div_last && (smpl_cnt != '0)) shift_reg <= shifted;
      if (last_bit) begin
        resp <= shifted;
        SS_n <= 1'b1;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_mnrch.sv
// tb/tb_spi_mnrch.sv - self-checking bench for spi_mnrch with a protocol-level slave model
module tb_spi_mnrch;

  // Front porch of 9 clk, then 16 bits of 32 clk each.
  localparam int LAT = 9 + 16 * 32;
  localparam time SCLK_PER = 320;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        snd;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  spi_mnrch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .snd   (snd),
    .cmd   (cmd),
    .done  (done),
    .resp  (resp),
    .SS_n  (SS_n),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .MISO  (MISO)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: loopback, or a mode-3 sensor that presents MSB at select and updates on trailing falls
  logic        loop_mode = 1'b1;
  logic [15:0] slv_word = '0;
  logic [15:0] slv_tx = '0;
  logic [15:0] slv_rx = '0;
  logic        slv_miso = 1'b0;
  logic        sl_ss = 1'b1;
  logic        sl_sclk = 1'b1;
  int          rises = 0;
  int          falls = 0;
  int          period_bad = 0;
  time         last_fall = 0;

  assign MISO = loop_mode ? MOSI : slv_miso;

  always @(SS_n or SCLK) begin
    if (SS_n === 1'b0 && sl_ss !== 1'b0) begin
      slv_tx     = slv_word;
      slv_miso   = slv_word[15];
      slv_rx     = '0;
      rises      = 0;
      falls      = 0;
      period_bad = 0;
    end else if (SS_n === 1'b0 && SCLK !== sl_sclk) begin
      if (SCLK === 1'b1) begin
        slv_rx = {slv_rx[14:0], MOSI};
        rises++;
      end else begin
        if (falls > 0 && ($time - last_fall) != SCLK_PER) period_bad++;
        last_fall = $time;
        falls++;
        if (rises > 0) begin
          slv_tx   = {slv_tx[14:0], 1'b0};
          slv_miso = slv_tx[15];
        end
      end
    end
    sl_ss   = SS_n;
    sl_sclk = SCLK;
  end

  // Line monitor: MOSI may only change in the clk where SCLK fell; SCLK high whenever deselected
  int   mosi_bad = 0;
  int   idle_bad = 0;
  logic p_ss = 1'b1;
  logic p_sclk = 1'b1;
  logic p_mosi = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && SS_n === 1'b0 && p_ss === 1'b0 && MOSI !== p_mosi &&
        !(p_sclk === 1'b1 && SCLK === 1'b0))
      mosi_bad++;
    if (SS_n === 1'b1 && SCLK !== 1'b1) idle_bad++;
    p_ss   = SS_n;
    p_sclk = SCLK;
    p_mosi = MOSI;
  end

  // Issue one transfer from a negedge; optional re-pulse of snd or reset at loop index
  task automatic do_xfer(input logic [15:0] c, input int resnd_at, input int rst_at,
                         output logic [15:0] r, output int lat, output logic start_ok);
    int unsigned start;
    cmd = c;
    snd = 1'b1;
    @(posedge clk);
    #1;
    snd = 1'b0;
    cmd = 16'($urandom);
    @(negedge clk);
    start    = cyc;
    start_ok = (SS_n === 1'b0) && (done === 1'b0);
    lat      = -1;
    for (int i = 0; i < 600; i++) begin
      if (i == resnd_at) begin
        snd = 1'b1;
        cmd = 16'($urandom);
      end else begin
        snd = 1'b0;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        lat = -2;
        break;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        lat = int'(cyc - start);
        break;
      end
    end
    snd = 1'b0;
    r   = resp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    snd   = 1'b0;
    cmd   = '0;
    repeat (3) @(negedge clk);
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b expected 1", SS_n); end
    checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", SCLK); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (resp !== 16'h0) begin errors++; $display("FAIL reset_resp: got %h expected 0000", resp); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [15:0] r;
    int          lat;
    logic        ok;
    loop_mode = 1'b1;
    do_xfer(16'hA5C3, -1, -1, r, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_start: SS_n=%b done=%b expected 0/0", SS_n, done); end
    checks++; if (r !== 16'hA5C3) begin errors++; $display("FAIL loop_resp: got %h expected a5c3", r); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL loop_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL loop_ss_end: got %b expected 1", SS_n); end
    repeat (5) @(negedge clk);
    checks++; if (done !== 1'b1 || resp !== 16'hA5C3) begin
      errors++; $display("FAIL loop_sticky: done=%b resp=%h expected 1/a5c3", done, resp); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL idle_sclk: got %0d bad cycles expected 0", idle_bad); end
  endtask

  task automatic test_sensor_read();
    logic [15:0] r;
    int          lat;
    logic        ok;
    loop_mode = 1'b0;
    slv_word  = 16'h1234;
    do_xfer(16'h8F00, -1, -1, r, lat, ok);
    checks++; if (slv_rx !== 16'h8F00) begin errors++; $display("FAIL sensor_decode: got %h expected 8f00", slv_rx); end
    checks++; if (r !== 16'h1234) begin errors++; $display("FAIL sensor_resp: got %h expected 1234", r); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL sensor_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_edges();
    logic [15:0] r;
    logic [15:0] c;
    int          lat;
    logic        ok;
    loop_mode = 1'b0;
    slv_word  = 16'($urandom);
    c         = 16'($urandom);
    do_xfer(c, -1, -1, r, lat, ok);
    checks++; if (falls != 16) begin errors++; $display("FAIL edge_falls: got %0d expected 16", falls); end
    checks++; if (rises != 16) begin errors++; $display("FAIL edge_rises: got %0d expected 16", rises); end
    checks++; if (period_bad != 0) begin errors++; $display("FAIL edge_period: got %0d bad periods expected 0", period_bad); end
    checks++; if (mosi_bad != 0) begin errors++; $display("FAIL mosi_timing: got %0d bad changes expected 0", mosi_bad); end
    checks++; if (r !== slv_word) begin errors++; $display("FAIL edge_resp: got %h expected %h", r, slv_word); end
  endtask

  task automatic test_ignore_snd();
    logic [15:0] r;
    int          lat;
    logic        ok;
    loop_mode = 1'b1;
    do_xfer(16'hA5C3, 100, -1, r, lat, ok);
    checks++; if (r !== 16'hA5C3) begin errors++; $display("FAIL resnd_resp: got %h expected a5c3", r); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL resnd_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] r;
    logic [15:0] c;
    int          lat;
    logic        ok;
    loop_mode = 1'b1;
    do_xfer(16'h5A3C, -1, 300, r, lat, ok);
    checks++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin
      errors++; $display("FAIL midrst_lines: SS_n=%b SCLK=%b expected 1/1", SS_n, SCLK); end
    checks++; if (done !== 1'b0 || resp !== 16'h0) begin
      errors++; $display("FAIL midrst_result: done=%b resp=%h expected 0/0000", done, resp); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    c = 16'($urandom);
    do_xfer(c, -1, -1, r, lat, ok);
    checks++; if (r !== c || lat != LAT) begin
      errors++; $display("FAIL midrst_recover: resp=%h lat=%0d expected %h/%0d", r, lat, c, LAT); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] r;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] w1;
    int          lat;
    logic        ok;
    loop_mode = 1'b0;
    c0 = 16'($urandom);
    c1 = 16'($urandom);
    slv_word = 16'($urandom);
    do_xfer(c0, -1, -1, r, lat, ok);
    checks++; if (r !== slv_word) begin errors++; $display("FAIL b2b_first: got %h expected %h", r, slv_word); end
    w1 = 16'($urandom);
    slv_word = w1;
    do_xfer(c1, -1, -1, r, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done_clear: accept flag %b expected 1", ok); end
    checks++; if (r !== w1 || slv_rx !== c1) begin
      errors++; $display("FAIL b2b_second: resp=%h rx=%h expected %h/%h", r, slv_rx, w1, c1); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, LAT); end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic [15:0] c;
    logic [15:0] exp_r;
    int          lat;
    logic        ok;
    for (int k = 0; k < 6; k++) begin
      loop_mode = k[0];
      slv_word  = 16'($urandom);
      c         = 16'($urandom);
      exp_r     = loop_mode ? c : slv_word;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_xfer(c, -1, -1, r, lat, ok);
      checks++; if (r !== exp_r || lat != LAT) begin
        errors++; $display("FAIL rand_%0d: resp=%h lat=%0d expected %h/%0d", k, r, lat, exp_r, LAT); end
      checks++; if (slv_rx !== c) begin errors++; $display("FAIL rand_rx_%0d: got %h expected %h", k, slv_rx, c); end
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_sensor_read();
    test_edges();
    test_ignore_snd();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
